uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter among `NUM_REQ` byte-stream requesters. Each requester sends packets, i.e. byte sequences terminated by a `last` flag. Once a requester wins, it holds the transmitter until its last byte is accepted or until it stalls past a watchdog limit. The block sits between the protocol engines (LFSR readout, command responses) and the UART's `tx_data/tx_ready/tx_ack` port.

---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/rr_picker.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Index width helper keeps single-entry vectors at one bit.
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int UART_DATA_W = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around, found via a double-width masked priority encoder.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;
    logic           found;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    // Low half holds requests at/after ptr, high half the wrapped ones.
    assign dbl = {req, req & mask};

    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (dbl[i] && !found) begin
                found = 1'b1;
                idx   = IW'(i % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART transmitter among
// NUM_REQ byte-stream requesters, with an owner-stall watchdog.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0]             req_last_i,
    output logic [NUM_REQ-1:0]             req_ack_o,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [UART_DATA_W-1:0]         tx_data_o,
    output logic                           tx_ready_o,
    input  logic                           tx_ack_i,
    output logic                           timeout_o
);

    localparam int IW    = idx_w(NUM_REQ);
    localparam int SW    = idx_w(TIMEOUT + 1);
    localparam bit WD_EN = (TIMEOUT != 0);

    arb_state_t state, state_n;

    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] pick_idx, ptr_inc;
    logic [SW-1:0] stall_cnt, stall_n, stall_inc;
    logic          timeout_n;
    logic          pick_any;
    logic          own_valid, own_last;

    logic [UART_DATA_W-1:0] data_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data_i[i*UART_DATA_W +: UART_DATA_W];
        end
    end

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req (req_valid_i),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign own_valid = req_valid_i[owner];
    assign own_last  = req_last_i[owner];

    assign ptr_inc = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // Saturating increment so the count never wraps when the watchdog is off.
    assign stall_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;

    always_comb begin
        grant_o    = '0;
        req_ack_o  = '0;
        tx_data_o  = '0;
        tx_ready_o = 1'b0;
        if (state == BUSY) begin
            grant_o[owner]   = 1'b1;
            tx_data_o        = data_arr[owner];
            tx_ready_o       = own_valid;
            req_ack_o[owner] = tx_ack_i && own_valid;
        end
    end

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        ptr_n     = ptr;
        stall_n   = stall_cnt;
        timeout_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = BUSY;
                    owner_n = pick_idx;
                    stall_n = '0;
                end
            end
            BUSY: begin
                if (own_valid) begin
                    stall_n = '0;
                    if (tx_ack_i && own_last) begin
                        state_n = IDLE;
                        ptr_n   = ptr_inc;
                    end
                end else begin
                    stall_n = stall_inc;
                    if (WD_EN && stall_inc == SW'(TIMEOUT)) begin
                        state_n   = IDLE;
                        ptr_n     = ptr_inc;
                        timeout_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            stall_cnt <= '0;
            timeout_o <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            ptr       <= ptr_n;
            stall_cnt <= stall_n;
            timeout_o <= timeout_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] req_data;
    logic [3:0]  req_valid, req_last, req_ack, grant;
    logic [7:0]  tx_data;
    logic        tx_ready, tx_ack, timeout;

    int checks = 0;
    int errors = 0;

    bit m_busy;
    int m_owner, m_ptr, m_stall;
    bit m_to;

    logic [3:0] e_grant, e_ack;
    logic [7:0] e_data;
    logic       e_ready;

    logic [3:0] o_grant, o_ack;
    logic [7:0] o_data;
    logic       o_ready, o_to;

    byte unsigned txlog[$];

    int k, n_to, quiet;
    int cnt[N];
    int rem[N];
    logic [3:0] fair_exp[10];

    uart_tx_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_ack_o   (req_ack),
        .grant_o     (grant),
        .tx_data_o   (tx_data),
        .tx_ready_o  (tx_ready),
        .tx_ack_i    (tx_ack),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL sim_time_limit observed=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_stall = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_expect();
        e_grant = '0;
        e_ack   = '0;
        e_data  = '0;
        e_ready = 1'b0;
        if (m_busy) begin
            e_grant[m_owner] = 1'b1;
            e_data           = req_data[m_owner*8 +: 8];
            e_ready          = req_valid[m_owner];
            e_ack[m_owner]   = tx_ack & req_valid[m_owner];
        end
    endtask

    task automatic model_adv();
        bit found;
        int j;
        if (!reset_n) begin
            model_reset();
        end else if (!m_busy) begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int c = 0; c < N; c++) begin
                j = (m_ptr + c) % N;
                if (req_valid[j] && !found) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = j;
                    m_stall = 0;
                end
            end
        end else begin
            m_to = 1'b0;
            if (req_valid[m_owner]) begin
                m_stall = 0;
                if (tx_ack && req_last[m_owner]) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end else begin
                m_stall++;
                if (m_stall == TO) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                    m_to   = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_expect();
        o_grant = grant;
        o_ack   = req_ack;
        o_data  = tx_data;
        o_ready = tx_ready;
        o_to    = timeout;
        chk("grant", grant, e_grant);
        chk("req_ack", req_ack, e_ack);
        chk("tx_data", tx_data, e_data);
        chk("tx_ready", tx_ready, e_ready);
        chk("timeout", timeout, m_to);
        if (tx_ready && tx_ack) txlog.push_back(tx_data);
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ack    = 1'b0;
        model_reset();
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        fair_exp = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0,
                     4'h4, 4'h0, 4'h8, 4'h0, 4'h1};

        // Reset state
        do_reset();
        chk("rst_grant", o_grant, 4'h0);
        chk("rst_ready", o_ready, 1'b0);
        chk("rst_timeout", o_to, 1'b0);

        // Single packet from requester 2
        txlog.delete();
        tx_ack    = 1'b1;
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data[23:16] = 8'h41;
        step();
        chk("t1_idle_grant", o_grant, 4'h0);
        for (int b = 0; b < 3; b++) begin
            req_data[23:16] = 8'(8'h41 + b);
            req_last[2]     = (b == 2);
            step();
            chk("t1_grant", o_grant, 4'b0100);
            chk("t1_data", o_data, 8'(8'h41 + b));
        end
        req_valid = '0;
        req_last  = '0;
        step();
        chk("t1_back_idle", o_grant, 4'h0);
        chk("t1_bytes", txlog.size(), 3);

        // Round-robin fairness with one-byte packets
        do_reset();
        tx_ack    = 1'b1;
        req_valid = 4'hf;
        req_last  = 4'hf;
        req_data  = 32'h03020100;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t2_grant_seq", o_grant, fair_exp[c]);
        end

        // Packet lock: req 1 waits for req 0's whole packet
        do_reset();
        tx_ack    = 1'b1;
        req_valid = 4'b0011;
        req_last  = 4'b0010;
        req_data[15:8] = 8'hB1;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            req_data[7:0] = 8'(8'hA0 + k);
            req_last[0]   = (k == 3);
            if (k == 4) req_valid[0] = 1'b0;
            step();
            chk("t3_ack1_locked", o_ack[1], 1'b0);
            if (o_ack[0]) k++;
        end
        chk("t3_bytes_req0", k, 4);
        step();
        chk("t3_ack1_after", o_ack[1], 1'b1);

        // UART backpressure mid-packet
        do_reset();
        tx_ack    = 1'b1;
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        req_data[15:8] = 8'h10;
        step();
        step();
        req_data[15:8] = 8'h11;
        tx_ack = 1'b0;
        repeat (10) begin
            step();
            chk("t4_no_ack", o_ack, 4'h0);
            chk("t4_data_held", o_data, 8'h11);
            chk("t4_no_timeout", o_to, 1'b0);
        end
        tx_ack = 1'b1;
        step();
        chk("t4_resume", o_ack, 4'b0010);

        // Watchdog: owner 3 stalls after its first byte
        do_reset();
        tx_ack    = 1'b1;
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        req_data[31:24] = 8'h33;
        step();
        step();
        chk("t5_first_byte", o_ack, 4'b1000);
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_data[7:0] = 8'h55;
        for (int c = 0; c < TO; c++) begin
            step();
            chk("t5_hold_grant", o_grant, 4'b1000);
            chk("t5_no_ack", o_ack, 4'h0);
            chk("t5_no_pulse", o_to, 1'b0);
        end
        step();
        chk("t5_pulse", o_to, 1'b1);
        chk("t5_released", o_grant, 4'h0);
        step();
        chk("t5_next_owner", o_grant, 4'b0001);
        chk("t5_pulse_end", o_to, 1'b0);

        // Asynchronous reset mid-packet
        do_reset();
        tx_ack    = 1'b1;
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data[23:16] = 8'h66;
        step();
        step();
        chk("t6_busy", o_ready, 1'b1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_ready", tx_ready, 1'b0);
        chk("t6_rst_grant", grant, 4'h0);
        chk("t6_rst_ack", req_ack, 4'h0);
        chk("t6_rst_data", tx_data, 8'h00);
        req_valid = 4'b1010;
        req_last  = 4'b1010;
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("t6_first_grant", o_grant, 4'b0010);

        // Randomized traffic against the model
        do_reset();
        n_to  = 0;
        quiet = 0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            rem[i] = $urandom_range(1, 4);
        end
        repeat (1500) begin
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 63) == 0) quiet = 7;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (quiet == 0) && ($urandom_range(0, 3) != 0);
                req_data[i*8 +: 8] = {i[1:0], cnt[i][5:0]};
                req_last[i] = (rem[i] == 1);
            end
            tx_ack = ($urandom_range(0, 3) != 0);
            step();
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) begin
                    cnt[i]++;
                    if (rem[i] == 1) rem[i] = $urandom_range(1, 4);
                    else rem[i]--;
                end
            end
            if (o_to) n_to++;
        end
        chk("t7_timeouts_seen", (n_to > 0), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
